// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pipe_pkg
// Purpose  : Shared types and helpers for the pipeline hazard/forwarding
//            controller: scoreboard tag entry, controller FSM state and the
//            forward-select width helper.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pipe_pkg;

    // Tag destination field is sized for the widest register address we
    // support; narrower register files are zero-extended into it.
    localparam int c_TAG_DST_W = 16;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                   valid;
        logic [c_TAG_DST_W-1:0] dst;
        logic                   load;
    } tag_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // Select encodes register file plus one code per tracked stage.
    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage : cpu_pipe_pkg
`default_nettype wire

// File: rtl/fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module   : fwd_lookup
// Purpose  : Priority scan of the in-flight scoreboard for one decode
//            operand. Youngest matching tag wins; a match whose data is not
//            yet available reports a hazard instead of a forward.
// Revision : 1.0  initial release
// ============================================================================
module fwd_lookup
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = 2
) (
    input  tag_t [FWD_STAGES-1:0]        i_tags,
    input  logic [c_TAG_DST_W-1:0]       i_src,
    input  logic                         i_use,
    input  logic [FWD_STAGES*DATA_W-1:0] i_stage_data,
    output logic [SEL_W-1:0]             o_sel,
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_hazard
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        o_sel    = SEL_W'(FWD_SEL_RF);
        o_data   = '0;
        o_hazard = 1'b0;
        if (i_use) begin
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (i_tags[i].valid && (i_tags[i].dst == i_src)) begin
                    if (!i_tags[i].load || (i >= LOAD_READY)) begin
                        o_sel    = SEL_W'(i + 1);
                        o_data   = i_stage_data[i*DATA_W +: DATA_W];
                        o_hazard = 1'b0;
                    end else begin
                        o_sel    = SEL_W'(FWD_SEL_RF);
                        o_data   = '0;
                        o_hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule : fwd_lookup
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard and forwarding controller. Keeps a shifting scoreboard of
//            in-flight destinations, forwards both decode operands from the
//            youngest ready stage, raises load-use stalls and a one-cycle
//            branch flush, and counts stalls/flushes with saturation.
//            State advances on the falling clock edge, in step with the
//            pipeline registers it shadows.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,   // must not exceed c_TAG_DST_W
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 1,
    parameter int BR_STAGE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    input  logic [REG_AW-1:0]                 id_dst,
    input  logic                              id_wb,
    input  logic                              id_load,
    input  logic [REG_AW-1:0]                 id_src_a,
    input  logic                              id_use_a,
    input  logic [REG_AW-1:0]                 id_src_b,
    input  logic                              id_use_b,
    input  logic [FWD_STAGES*DATA_W-1:0]      stage_data,
    input  logic                              branch_taken,
    output logic [fwd_sel_w(FWD_STAGES)-1:0]  fwd_a_sel,
    output logic [DATA_W-1:0]                 fwd_a_data,
    output logic [fwd_sel_w(FWD_STAGES)-1:0]  fwd_b_sel,
    output logic [DATA_W-1:0]                 fwd_b_data,
    output logic                              stall,
    output logic                              flush,
    output logic [FWD_STAGES-1:0]             tag_valid,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic [CNT_W-1:0]                  flush_cnt
);

    localparam int c_SEL_W = fwd_sel_w(FWD_STAGES);

    tag_t [FWD_STAGES-1:0]  r_tag_q;
    tag_t [FWD_STAGES-1:0]  w_tag_d;
    hz_state_e              r_state_q;
    hz_state_e              w_state_d;
    logic [CNT_W-1:0]       r_stall_cnt_q;
    logic [CNT_W-1:0]       w_stall_cnt_d;
    logic [CNT_W-1:0]       r_flush_cnt_q;
    logic [CNT_W-1:0]       w_flush_cnt_d;

    logic [c_TAG_DST_W-1:0] w_src_a_ext;
    logic [c_TAG_DST_W-1:0] w_src_b_ext;
    logic [c_TAG_DST_W-1:0] w_dst_ext;
    logic                   w_hazard_a;
    logic                   w_hazard_b;
    logic                   w_branch;

    // Widen register addresses into the tag destination field.
    always_comb begin
        w_src_a_ext                = '0;
        w_src_b_ext                = '0;
        w_dst_ext                  = '0;
        w_src_a_ext[REG_AW-1:0]    = id_src_a;
        w_src_b_ext[REG_AW-1:0]    = id_src_b;
        w_dst_ext[REG_AW-1:0]      = id_dst;
    end

    fwd_lookup #(
        .DATA_W     (DATA_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (c_SEL_W)
    ) u_fwd_a (
        .i_tags       (r_tag_q),
        .i_src        (w_src_a_ext),
        .i_use        (id_use_a),
        .i_stage_data (stage_data),
        .o_sel        (fwd_a_sel),
        .o_data       (fwd_a_data),
        .o_hazard     (w_hazard_a)
    );

    fwd_lookup #(
        .DATA_W     (DATA_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (c_SEL_W)
    ) u_fwd_b (
        .i_tags       (r_tag_q),
        .i_src        (w_src_b_ext),
        .i_use        (id_use_b),
        .i_stage_data (stage_data),
        .o_sel        (fwd_b_sel),
        .o_data       (fwd_b_data),
        .o_hazard     (w_hazard_b)
    );

    // A taken branch only counts in RUN; during FLUSH it is a squashed slot.
    assign w_branch = branch_taken && (r_state_q == ST_RUN);
    assign flush    = (r_state_q == ST_FLUSH);
    assign stall    = issue_valid && (w_hazard_a || w_hazard_b)
                      && (r_state_q == ST_RUN) && !branch_taken;

    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

    generate
        for (genvar g = 0; g < FWD_STAGES; g++) begin : g_tag_valid
            assign tag_valid[g] = r_tag_q[g].valid;
        end
    endgenerate

    // Next scoreboard, FSM state and saturating counters.
    always_comb begin
        w_tag_d[0].valid = issue_valid && id_wb && !stall && !flush;
        w_tag_d[0].dst   = w_dst_ext;
        w_tag_d[0].load  = id_load;
        for (int i = 1; i < FWD_STAGES; i++) begin
            w_tag_d[i] = r_tag_q[i-1];
        end
        // Wrong-path instructions and the decode slot die with the branch.
        if (w_branch) begin
            for (int i = 0; i <= BR_STAGE; i++) begin
                w_tag_d[i].valid = 1'b0;
            end
        end

        w_state_d = (r_state_q == ST_RUN && w_branch) ? ST_FLUSH : ST_RUN;

        w_stall_cnt_d = r_stall_cnt_q;
        if (stall && (r_stall_cnt_q != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end

        w_flush_cnt_d = r_flush_cnt_q;
        if (w_branch && (r_flush_cnt_q != {CNT_W{1'b1}})) begin
            w_flush_cnt_d = r_flush_cnt_q + CNT_W'(1);
        end
    end

    // Register all controller state on the pipeline's falling edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_tag_q       <= '0;
            r_state_q     <= ST_RUN;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_tag_q       <= w_tag_d;
            r_state_q     <= w_state_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl. A second
//            instance with a 4-bit counter shares the stimulus to exercise
//            counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   id_dst;
    logic            id_wb;
    logic            id_load;
    logic [AW-1:0]   id_src_a;
    logic            id_use_a;
    logic [AW-1:0]   id_src_b;
    logic            id_use_b;
    logic [NS*DW-1:0] stage_data;
    logic            branch_taken;

    logic [SW-1:0]   fwd_a_sel, fwd_b_sel;
    logic [DW-1:0]   fwd_a_data, fwd_b_data;
    logic            stall, flush;
    logic [NS-1:0]   tag_valid;
    logic [15:0]     stall_cnt, flush_cnt;

    logic [SW-1:0]   s_fwd_a_sel, s_fwd_b_sel;
    logic [DW-1:0]   s_fwd_a_data, s_fwd_b_data;
    logic            s_stall, s_flush;
    logic [NS-1:0]   s_tag_valid;
    logic [3:0]      s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [SW-1:0] sel_a;
        logic [DW-1:0] data_a;
        logic [SW-1:0] sel_b;
        logic [DW-1:0] data_b;
        logic          stall;
        logic          flush;
        logic [NS-1:0] tv;
        int            scnt;
        int            fcnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .id_dst       (id_dst),
        .id_wb        (id_wb),
        .id_load      (id_load),
        .id_src_a     (id_src_a),
        .id_use_a     (id_use_a),
        .id_src_b     (id_src_b),
        .id_use_b     (id_use_b),
        .stage_data   (stage_data),
        .branch_taken (branch_taken),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_a_data   (fwd_a_data),
        .fwd_b_sel    (fwd_b_sel),
        .fwd_b_data   (fwd_b_data),
        .stall        (stall),
        .flush        (flush),
        .tag_valid    (tag_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .id_dst       (id_dst),
        .id_wb        (id_wb),
        .id_load      (id_load),
        .id_src_a     (id_src_a),
        .id_use_a     (id_use_a),
        .id_src_b     (id_src_b),
        .id_use_b     (id_use_b),
        .stage_data   (stage_data),
        .branch_taken (branch_taken),
        .fwd_a_sel    (s_fwd_a_sel),
        .fwd_a_data   (s_fwd_a_data),
        .fwd_b_sel    (s_fwd_b_sel),
        .fwd_b_data   (s_fwd_b_data),
        .stall        (s_stall),
        .flush        (s_flush),
        .tag_valid    (s_tag_valid),
        .stall_cnt    (s_stall_cnt),
        .flush_cnt    (s_flush_cnt)
    );

    // Expected forwarded value for a given select code.
    function automatic logic [DW-1:0] sdat(input logic [SW-1:0] sel);
        case (sel)
            2'd1:    return stage_data[0*DW +: DW];
            2'd2:    return stage_data[1*DW +: DW];
            2'd3:    return stage_data[2*DW +: DW];
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge+1, compare mid-cycle, then let the edge commit.
    task automatic step(
        input logic rst, input logic iv, input logic [AW-1:0] dst, input logic wb,
        input logic ld, input logic [AW-1:0] sa, input logic ua,
        input logic [AW-1:0] sb, input logic ub, input logic br,
        input logic [SW-1:0] esa, input logic [SW-1:0] esb, input logic est,
        input logic efl, input logic [NS-1:0] etv, input int escnt, input int efcnt);
        exp_t e;
        exp_t o;
        reset        = rst;
        issue_valid  = iv;
        id_dst       = dst;
        id_wb        = wb;
        id_load      = ld;
        id_src_a     = sa;
        id_use_a     = ua;
        id_src_b     = sb;
        id_use_b     = ub;
        branch_taken = br;
        e.sel_a  = esa;
        e.data_a = sdat(esa);
        e.sel_b  = esb;
        e.data_b = sdat(esb);
        e.stall  = est;
        e.flush  = efl;
        e.tv     = etv;
        e.scnt   = escnt;
        e.fcnt   = efcnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        chk("fwd_a_sel",  32'(fwd_a_sel),  32'(o.sel_a));
        chk("fwd_a_data", fwd_a_data,      o.data_a);
        chk("fwd_b_sel",  32'(fwd_b_sel),  32'(o.sel_b));
        chk("fwd_b_data", fwd_b_data,      o.data_b);
        chk("stall",      32'(stall),      32'(o.stall));
        chk("flush",      32'(flush),      32'(o.flush));
        chk("tag_valid",  32'(tag_valid),  32'(o.tv));
        chk("stall_cnt",  32'(stall_cnt),  32'(o.scnt));
        chk("flush_cnt",  32'(flush_cnt),  32'(o.fcnt));
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'((o.scnt > 15) ? 15 : o.scnt));
        @(negedge clk);
        #1;
    endtask

    initial begin
        stage_data   = {32'h3333_C0DE, 32'h2222_B0B0, 32'h1111_A0A0};
        reset        = 1'b1;
        issue_valid  = 1'b0;
        id_dst       = '0;
        id_wb        = 1'b0;
        id_load      = 1'b0;
        id_src_a     = '0;
        id_use_a     = 1'b0;
        id_src_b     = '0;
        id_use_b     = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Reset state
        step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        // ALU chain: r3 forwarded from EX, then older stages, then retired
        step(0, 1, 3, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        step(0, 1, 0, 0, 0,  3, 1, 0, 0, 0,  1, 0, 0, 0, 3'b001, 0, 0);
        step(0, 1, 0, 0, 0,  3, 1, 0, 0, 0,  2, 0, 0, 0, 3'b010, 0, 0);
        step(0, 1, 0, 0, 0,  3, 1, 0, 0, 0,  3, 0, 0, 0, 3'b100, 0, 0);
        step(0, 1, 0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        // Load-use on operand B: one stall cycle, then forward from stage 1
        step(0, 1, 5, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        step(0, 1, 6, 1, 0,  0, 0, 5, 1, 0,  0, 0, 1, 0, 3'b001, 0, 0);
        step(0, 1, 6, 1, 0,  0, 0, 5, 1, 0,  0, 2, 0, 0, 3'b010, 1, 0);
        // Double write of r2 at stages 2 and 0: youngest wins
        step(0, 1, 2, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b101, 1, 0);
        step(0, 1, 7, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b011, 1, 0);
        step(0, 1, 2, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111, 1, 0);
        step(0, 1, 8, 1, 0,  2, 1, 7, 1, 0,  1, 2, 0, 0, 3'b111, 1, 0);
        // Branch with full scoreboard and a simultaneous load-use hazard
        step(0, 1, 9, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111, 1, 0);
        step(0, 1, 10, 1, 0, 9, 1, 0, 0, 1,  0, 0, 0, 0, 3'b111, 1, 0);
        step(0, 1, 11, 1, 0, 8, 1, 9, 1, 1,  3, 0, 0, 1, 3'b100, 1, 1);
        step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 1, 1);
        // Reset asserted during a load-use stall
        step(0, 1, 5, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000, 1, 1);
        step(1, 1, 0, 0, 0,  0, 0, 5, 1, 0,  0, 0, 1, 0, 3'b001, 1, 1);
        step(0, 1, 0, 0, 0,  0, 0, 5, 1, 0,  0, 0, 0, 0, 3'b000, 0, 0);
        // Twenty load-use stalls: 16-bit counter tracks, 4-bit counter pins at 15
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 (k == 1) ? 3'b000 : 3'b100, k - 1, 0);
            step(0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 3'b001, k - 1, 0);
            step(0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 2, 0, 0, 3'b010, k, 0);
        end
        chk("final_stall_cnt", 32'(stall_cnt), 32'd20);
        chk("final_sat_cnt",   32'(s_stall_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
